four_bit_1x2_demux_buffered: RTL and testbench

- Registered 1-to-2 demultiplexer. It is the inverse of the 4-bit 2x1 mux in the adder/subtractor datapath.
- Accepts one WIDTH-bit word per handshake and steers it by Select into one of two per-channel FIFOs: channel 1 when Select=1, channel 0 when Select=0.
- Each channel presents its FIFO head with an independent valid/ready handshake.
- Used to route adder/subtractor results to two downstream consumers without stalling the other channel.

---
 rtl/four_bit_1x2_demux_buffered_pkg.sv | 13 +
 rtl/four_bit_1x2_demux_buffered_channel_fifo.sv | 60 ++++++
 rtl/four_bit_1x2_demux_buffered.sv | 71 +++++++
 tb/tb_four_bit_1x2_demux_buffered.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/four_bit_1x2_demux_buffered_pkg.sv
// Shared defaults, channel indices and sizing helpers for the buffered 1x2 demux.
package four_bit_demux_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
  localparam int CH_0 = 0;
  localparam int CH_1 = 1;
  localparam int CNT_W = 8;

  // Pointer width is log2(DEPTH); clamp to 1 so a degenerate depth still elaborates.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/four_bit_1x2_demux_buffered_channel_fifo.sv
// Per-channel FIFO: pushed word visible at head the next cycle, no fall-through.
// Latency 1 cycle push-to-head; push while full is only taken together with a pop.
// Head holds the last popped word (0 after reset) while the FIFO is empty.
module demux_channel_fifo
  import four_bit_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_BITS-1:0] cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  ptr_t rd_ptr, wr_ptr;
  cnt_t count;
  logic pop_ok, push_ok;

  assign full    = (count == cnt_t'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head_data = empty ? last_q : mem[rd_ptr];

  // Storage is not reset: occupancy is tracked by count, so stale entries are never seen.
  always_ff @(posedge Clock) begin
    if (!Reset && push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/four_bit_1x2_demux_buffered.sv
// Registered 1-to-2 demux steering each accepted word into a per-channel FIFO by Select.
// Latency 1 cycle accept-to-output; In_Ready depends only on the selected channel (full but popping counts as ready).
// Optional macro DEMUX_XFER_COUNT_EN adds 8-bit per-channel pop counters Count_1/Count_0.
module four_bit_1x2_demux_buffered
  import four_bit_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             In_Valid,
  input  logic             Select,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out_1,
  output logic             Out_1_Valid,
  input  logic             Out_1_Ready,
  output logic [WIDTH-1:0] Out_0,
  output logic             Out_0_Valid,
  input  logic             Out_0_Ready
`ifdef DEMUX_XFER_COUNT_EN
  ,
  output logic [CNT_W-1:0] Count_1,
  output logic [CNT_W-1:0] Count_0
`endif
);
  logic [1:0]       push, pop, full, empty;
  logic [WIDTH-1:0] head [2];
  logic             accept;

  assign pop[CH_1] = ~empty[CH_1] & Out_1_Ready;
  assign pop[CH_0] = ~empty[CH_0] & Out_0_Ready;

  // A full channel that drains this cycle frees the slot the incoming word needs.
  assign In_Ready = Select ? (~full[CH_1] | pop[CH_1]) : (~full[CH_0] | pop[CH_0]);
  assign accept   = In_Valid & In_Ready;

  assign push[CH_1] = accept & Select;
  assign push[CH_0] = accept & ~Select;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    demux_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .Clock     (Clock),
      .Reset     (Reset),
      .push      (push[ch]),
      .push_data (In),
      .pop       (pop[ch]),
      .full      (full[ch]),
      .empty     (empty[ch]),
      .head_data (head[ch])
    );
  end

  assign Out_1       = head[CH_1];
  assign Out_1_Valid = ~empty[CH_1];
  assign Out_0       = head[CH_0];
  assign Out_0_Valid = ~empty[CH_0];

`ifdef DEMUX_XFER_COUNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Count_1 <= '0;
      Count_0 <= '0;
    end else begin
      if (pop[CH_1]) Count_1 <= Count_1 + CNT_W'(1);
      if (pop[CH_0]) Count_0 <= Count_0 + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_four_bit_1x2_demux_buffered.sv
// Scoreboard bench: per-channel expected queues, continuous negedge monitor plus scenario tasks.
module tb_four_bit_1x2_demux_buffered;
  localparam int W = 4;
  localparam int D = 2;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] In = '0;
  logic         In_Valid = 1'b0;
  logic         Select = 1'b0;
  logic         In_Ready;
  logic [W-1:0] Out_1, Out_0;
  logic         Out_1_Valid, Out_0_Valid;
  logic         Out_1_Ready = 1'b0;
  logic         Out_0_Ready = 1'b0;
`ifdef DEMUX_XFER_COUNT_EN
  logic [7:0]   Count_1, Count_0;
  logic [7:0]   exp_cnt1 = '0, exp_cnt0 = '0;
`endif

  four_bit_1x2_demux_buffered dut (
    .Clock(Clock), .Reset(Reset), .In(In), .In_Valid(In_Valid), .Select(Select),
    .In_Ready(In_Ready),
    .Out_1(Out_1), .Out_1_Valid(Out_1_Valid), .Out_1_Ready(Out_1_Ready),
    .Out_0(Out_0), .Out_0_Valid(Out_0_Valid), .Out_0_Ready(Out_0_Ready)
`ifdef DEMUX_XFER_COUNT_EN
    , .Count_1(Count_1), .Count_0(Count_0)
`endif
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] last1 = '0, last0 = '0;
  logic         exp_rdy;
  bit           pop1, pop0, accepted;

  // Inputs change 1 time unit after posedge, so negedge sees the values the next edge will use.
  always @(negedge Clock) begin
    accepted = 1'b0;
    if (Reset) begin
      q1.delete(); q0.delete();
      last1 = '0; last0 = '0;
`ifdef DEMUX_XFER_COUNT_EN
      exp_cnt1 = '0; exp_cnt0 = '0;
`endif
    end else begin
      tests++;
      if (Out_1_Valid !== (q1.size() != 0)) begin
        fails++; $display("FAIL mon_valid1: got %b want %b", Out_1_Valid, q1.size() != 0);
      end
      tests++;
      if (Out_0_Valid !== (q0.size() != 0)) begin
        fails++; $display("FAIL mon_valid0: got %b want %b", Out_0_Valid, q0.size() != 0);
      end
      tests++;
      if (Out_1 !== ((q1.size() != 0) ? q1[0] : last1)) begin
        fails++; $display("FAIL mon_out1: got %h want %h", Out_1, (q1.size() != 0) ? q1[0] : last1);
      end
      tests++;
      if (Out_0 !== ((q0.size() != 0) ? q0[0] : last0)) begin
        fails++; $display("FAIL mon_out0: got %h want %h", Out_0, (q0.size() != 0) ? q0[0] : last0);
      end
      pop1 = (q1.size() != 0) && Out_1_Ready;
      pop0 = (q0.size() != 0) && Out_0_Ready;
      exp_rdy = Select ? ((q1.size() < D) || pop1) : ((q0.size() < D) || pop0);
      tests++;
      if (In_Ready !== exp_rdy) begin
        fails++; $display("FAIL mon_in_ready: got %b want %b (sel %b)", In_Ready, exp_rdy, Select);
      end
`ifdef DEMUX_XFER_COUNT_EN
      tests++;
      if (Count_1 !== exp_cnt1 || Count_0 !== exp_cnt0) begin
        fails++; $display("FAIL mon_counts: got %0d/%0d want %0d/%0d", Count_1, Count_0, exp_cnt1, exp_cnt0);
      end
      if (pop1) exp_cnt1 = exp_cnt1 + 8'd1;
      if (pop0) exp_cnt0 = exp_cnt0 + 8'd1;
`endif
      if (pop1) last1 = q1.pop_front();
      if (pop0) last0 = q0.pop_front();
      if (In_Valid && exp_rdy) begin
        accepted = 1'b1;
        if (Select) q1.push_back(In); else q0.push_back(In);
      end
    end
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic drain();
    int n = 0;
    Out_1_Ready = 1'b1; Out_0_Ready = 1'b1; In_Valid = 1'b0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 50) begin step(); n++; end
    tests++;
    if (q1.size() != 0 || q0.size() != 0) begin
      fails++; $display("FAIL drain_timeout: got %0d/%0d left want 0/0", q1.size(), q0.size());
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; In_Valid = 1'b0; step(); step(); Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    Select = 1'b0;
    #1;
    tests++;
    if (Out_1_Valid !== 1'b0 || Out_0_Valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b%b want 00", Out_1_Valid, Out_0_Valid);
    end
    tests++;
    if (Out_1 !== 4'h0 || Out_0 !== 4'h0) begin
      fails++; $display("FAIL reset_data: got %h/%h want 0/0", Out_1, Out_0);
    end
    tests++;
    if (In_Ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", In_Ready); end
    step();
  endtask

  task automatic test_single();
    Out_1_Ready = 1'b1; Out_0_Ready = 1'b0;
    Select = 1'b1; In = 4'hA; In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    #1;
    tests++;
    if (Out_1 !== 4'hA || Out_1_Valid !== 1'b1) begin
      fails++; $display("FAIL single_out1: got %h v%b want a v1", Out_1, Out_1_Valid);
    end
    tests++;
    if (Out_0_Valid !== 1'b0) begin fails++; $display("FAIL single_valid0: got %b want 0", Out_0_Valid); end
    step();
    tests++;
    if (Out_1_Valid !== 1'b0 || Out_1 !== 4'hA) begin
      fails++; $display("FAIL single_hold1: got %h v%b want a v0", Out_1, Out_1_Valid);
    end
  endtask

  task automatic test_full();
    Out_0_Ready = 1'b0; Out_1_Ready = 1'b0;
    Select = 1'b0; In = 4'h3; In_Valid = 1'b1; step();
    In = 4'h5; step();
    In_Valid = 1'b0; Select = 1'b0; #1;
    tests++;
    if (In_Ready !== 1'b0) begin fails++; $display("FAIL full_ready_sel0: got %b want 0", In_Ready); end
    Select = 1'b1; #1;
    tests++;
    if (In_Ready !== 1'b1) begin fails++; $display("FAIL full_ready_sel1: got %b want 1", In_Ready); end
    step();
    tests++;
    if (Out_0 !== 4'h3 || Out_0_Valid !== 1'b1) begin
      fails++; $display("FAIL full_hold0: got %h v%b want 3 v1", Out_0, Out_0_Valid);
    end
  endtask

  task automatic test_push_pop_full();
    Select = 1'b0; In = 4'h7; In_Valid = 1'b1; Out_0_Ready = 1'b1; #1;
    tests++;
    if (In_Ready !== 1'b1) begin fails++; $display("FAIL pp_ready: got %b want 1", In_Ready); end
    step();
    In_Valid = 1'b0; #1;
    tests++;
    if (Out_0 !== 4'h5) begin fails++; $display("FAIL pp_second: got %h want 5", Out_0); end
    step();
    tests++;
    if (Out_0 !== 4'h7) begin fails++; $display("FAIL pp_third: got %h want 7", Out_0); end
    step();
    tests++;
    if (Out_0_Valid !== 1'b0) begin fails++; $display("FAIL pp_empty: got %b want 0", Out_0_Valid); end
  endtask

  task automatic test_interleave();
    Out_1_Ready = 1'b1; Out_0_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Select = (i % 2 == 0); In = 4'(i + 1); In_Valid = 1'b1; step();
    end
    In_Valid = 1'b0;
    drain();
    tests++;
    if (last1 !== 4'h3 || last0 !== 4'h4) begin
      fails++; $display("FAIL interleave_last: got %h/%h want 3/4", last1, last0);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d = '0;
    logic s = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!In_Valid || accepted) begin
        In_Valid = ($urandom_range(0, 3) != 0);
        d = W'($urandom); s = $urandom_range(0, 1) == 1;
      end
      In = d; Select = s;
      Out_1_Ready = $urandom_range(0, 2) != 0;
      Out_0_Ready = $urandom_range(0, 3) == 0;
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    Out_1_Ready = 1'b0; Out_0_Ready = 1'b0;
    Select = 1'b1; In = 4'h9; In_Valid = 1'b1; step();
    Select = 1'b0; In = 4'h6; step();
    In_Valid = 1'b0;
    Out_1_Ready = 1'b1; Out_0_Ready = 1'b1;
    Reset = 1'b1; step(); Reset = 1'b0; #1;
    tests++;
    if (Out_1_Valid !== 1'b0 || Out_0_Valid !== 1'b0) begin
      fails++; $display("FAIL midreset_valid: got %b%b want 00", Out_1_Valid, Out_0_Valid);
    end
    tests++;
    if (Out_1 !== 4'h0 || Out_0 !== 4'h0) begin
      fails++; $display("FAIL midreset_data: got %h/%h want 0/0", Out_1, Out_0);
    end
    step();
  endtask

`ifdef DEMUX_XFER_COUNT_EN
  task automatic test_count();
    do_reset();
    Out_1_Ready = 1'b1; Select = 1'b1;
    for (int i = 0; i < 3; i++) begin In = 4'(i + 8); In_Valid = 1'b1; step(); end
    In_Valid = 1'b0; step(); step();
    tests++;
    if (Count_1 !== 8'd3) begin fails++; $display("FAIL count1_three: got %0d want 3", Count_1); end
    In = 4'hC; In_Valid = 1'b1; step(); In_Valid = 1'b0;
    Reset = 1'b1; step(); Reset = 1'b0; #1;
    tests++;
    if (Count_1 !== 8'd0) begin fails++; $display("FAIL count1_reset: got %0d want 0", Count_1); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full();
    test_push_pop_full();
    test_interleave();
    test_back_to_back();
    test_reset_mid();
`ifdef DEMUX_XFER_COUNT_EN
    test_count();
`endif
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
